// File: rtl/csr_access_controller_if.sv
// Bundle of the execute-stage request/response handshake and the shared CSR bus.
// master: the controller's view (accepts requests, drives the CSR bus strobes).
// slave:  the environment's view (execute stage plus the OR-combined responders).
interface csr_access_controller_if;
  // execute stage request
  logic        requestValid;
  logic        requestReady;
  logic [2:0]  requestOp;
  logic [11:0] requestAddress;
  logic [31:0] requestRs1Data;
  logic [4:0]  requestZimm;
  // execute stage response
  logic        responseValid;
  logic        responseReady;
  logic [31:0] responseData;
  logic        responseIllegal;
  // CSR register bus
  logic        csrReadEnable;
  logic [11:0] csrReadAddress;
  logic [31:0] csrReadData;
  logic        csrRequestOutput;
  logic        csrWriteEnable;
  logic [11:0] csrWriteAddress;
  logic [31:0] csrWriteData;

  modport master (
    input  requestValid, requestOp, requestAddress, requestRs1Data, requestZimm,
    input  responseReady, csrReadData, csrRequestOutput,
    output requestReady, responseValid, responseData, responseIllegal,
    output csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData
  );

  modport slave (
    output requestValid, requestOp, requestAddress, requestRs1Data, requestZimm,
    output responseReady, csrReadData, csrRequestOutput,
    input  requestReady, responseValid, responseData, responseIllegal,
    input  csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData
  );
endinterface

// File: rtl/csr_access_controller.sv
// Zicsr initiator: runs one CSRRW/S/C(I) read-modify-write per request on the shared CSR bus.
// Latency accept->responseValid: 1 (bad funct3), 2 (no write / illegal after read), 3 (with write).
// One instruction in flight; requestReady only in IDLE, response held until responseReady.
// Ports: clk, rst (async active-low), bus (master modport: request/response handshake + CSR bus).
module csr_access_controller #(
  parameter bit READONLY_CHECK = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  csr_access_controller_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESPOND} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;            // funct3[1:0]: 01 RW, 10 RS, 11 RC
  logic [11:0] addr_q, addr_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] old_q, old_d;
  logic        nowrite_q, nowrite_d;
  logic        illegal_q, illegal_d;

  logic [31:0] req_operand;
  logic [31:0] new_value;

  // Immediate forms take the zero-extended zimm instead of rs1.
  assign req_operand = bus.requestOp[2] ? {27'b0, bus.requestZimm} : bus.requestRs1Data;

  always_comb begin
    new_value = operand_q;
    case (op_q)
      2'b10:   new_value = old_q | operand_q;
      2'b11:   new_value = old_q & ~operand_q;
      default: new_value = operand_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    operand_d = operand_q;
    old_d     = old_q;
    nowrite_d = nowrite_q;
    illegal_d = illegal_q;

    bus.requestReady    = 1'b0;
    bus.responseValid   = 1'b0;
    bus.responseData    = 32'h0;
    bus.responseIllegal = 1'b0;
    bus.csrReadEnable   = 1'b0;
    bus.csrReadAddress  = 12'h0;
    bus.csrWriteEnable  = 1'b0;
    bus.csrWriteAddress = 12'h0;
    bus.csrWriteData    = 32'h0;

    case (state_q)
      IDLE: begin
        // Gated by rst so every output is low while reset is held.
        bus.requestReady = rst;
        if (bus.requestValid) begin
          op_d      = bus.requestOp[1:0];
          addr_d    = bus.requestAddress;
          operand_d = req_operand;
          old_d     = 32'h0;
          // Set/clear with a zero operand leaves the CSR untouched; RW always writes.
          nowrite_d = (bus.requestOp[1:0] != 2'b01) && (req_operand == 32'h0);
          if (bus.requestOp[1:0] == 2'b00) begin
            illegal_d = 1'b1;
            state_d   = RESPOND;
          end else begin
            illegal_d = 1'b0;
            state_d   = READ;
          end
        end
      end

      READ: begin
        bus.csrReadEnable  = 1'b1;
        bus.csrReadAddress = addr_q;
        old_d              = bus.csrReadData;
        if (!bus.csrRequestOutput) begin
          illegal_d = 1'b1;
          state_d   = RESPOND;
        end else if (nowrite_q) begin
          state_d   = RESPOND;
        end else if (READONLY_CHECK && (addr_q[11:10] == 2'b11)) begin
          illegal_d = 1'b1;
          state_d   = RESPOND;
        end else begin
          state_d   = WRITE;
        end
      end

      WRITE: begin
        bus.csrWriteEnable  = 1'b1;
        bus.csrWriteAddress = addr_q;
        bus.csrWriteData    = new_value;
        state_d             = RESPOND;
      end

      RESPOND: begin
        bus.responseValid   = 1'b1;
        bus.responseData    = illegal_q ? 32'h0 : old_q;
        bus.responseIllegal = illegal_q;
        if (bus.responseReady) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      addr_q    <= 12'h0;
      operand_q <= 32'h0;
      old_q     <= 32'h0;
      nowrite_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      operand_q <= operand_d;
      old_q     <= old_d;
      nowrite_q <= nowrite_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_access_controller.sv
// Directed bench for csr_access_controller with a two-register CSR responder
// (0x300 read/write, reset 0x12; 0xC00 read-only constant 0xABCD).
module tb_csr_access_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;

  csr_access_controller_if bus();

  csr_access_controller #(.READONLY_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- responder model ----------------
  logic [31:0] csr300 = 32'h12;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  int          bus_err = 0;

  always_comb begin
    bus.csrRequestOutput = 1'b0;
    bus.csrReadData      = 32'h0;
    if (bus.csrReadEnable && bus.csrReadAddress == 12'h300) begin
      bus.csrRequestOutput = 1'b1;
      bus.csrReadData      = csr300;
    end else if (bus.csrReadEnable && bus.csrReadAddress == 12'hC00) begin
      bus.csrRequestOutput = 1'b1;
      bus.csrReadData      = 32'h0000_ABCD;
    end
  end

  always @(posedge clk) begin
    if (bus.csrReadEnable) rd_cnt <= rd_cnt + 1;
    if (bus.csrWriteEnable) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= bus.csrWriteData;
      if (bus.csrWriteAddress == 12'h300) csr300 <= bus.csrWriteData;
    end
  end

  // Bus hygiene: idle addresses/data are zero, strobes never overlap.
  always @(negedge clk) begin
    if ((!bus.csrReadEnable && bus.csrReadAddress != 12'h0) ||
        (!bus.csrWriteEnable && (bus.csrWriteAddress != 12'h0 || bus.csrWriteData != 32'h0)) ||
        (bus.csrReadEnable && bus.csrWriteEnable))
      bus_err <= bus_err + 1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one instruction (called at a negedge, returns at a negedge in IDLE).
  // hold = cycles responseReady stays low while the response is checked for stability.
  task automatic run_csr(input string name, input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] rs1, input logic [4:0] zimm, input int hold,
                         input logic [31:0] exp_data, input logic exp_ill, input int exp_lat,
                         input int exp_rd, input int exp_wr, input logic [31:0] exp_wdat);
    int rd0, wr0, lat;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    check({name, "/reqrdy"}, 32'(bus.requestReady), 32'd1);
    bus.requestValid   = 1'b1;
    bus.requestOp      = op;
    bus.requestAddress = addr;
    bus.requestRs1Data = rs1;
    bus.requestZimm    = zimm;
    @(posedge clk);
    @(negedge clk);
    bus.requestValid = 1'b0;
    lat = 1;
    while (!bus.responseValid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "/rspvld"}, 32'(bus.responseValid), 32'd1);
    check({name, "/lat"}, lat, exp_lat);
    check({name, "/data"}, bus.responseData, exp_data);
    check({name, "/ill"}, 32'(bus.responseIllegal), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      // A competing request while busy must be ignored.
      bus.requestValid   = 1'b1;
      bus.requestOp      = 3'b001;
      bus.requestAddress = 12'h300;
      bus.requestRs1Data = 32'h55;
      @(negedge clk);
      check({name, "/hold_vld"}, 32'(bus.responseValid), 32'd1);
      check({name, "/hold_data"}, bus.responseData, exp_data);
      check({name, "/hold_rdy"}, 32'(bus.requestReady), 32'd0);
    end
    bus.requestValid  = 1'b0;
    bus.responseReady = 1'b1;
    @(negedge clk);
    bus.responseReady = 1'b0;
    check({name, "/done_vld"}, 32'(bus.responseValid), 32'd0);
    check({name, "/reads"}, rd_cnt - rd0, exp_rd);
    check({name, "/writes"}, wr_cnt - wr0, exp_wr);
    if (exp_wr != 0) check({name, "/wdata"}, last_wdata, exp_wdat);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.requestValid   = 1'b1;   // asserted during reset: must not be accepted
    bus.requestOp      = 3'b001;
    bus.requestAddress = 12'h300;
    bus.requestRs1Data = 32'h0;
    bus.requestZimm    = 5'h0;
    bus.responseReady  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst/reqrdy", 32'(bus.requestReady), 32'd0);
    check("rst/rspvld", 32'(bus.responseValid), 32'd0);
    check("rst/rden", 32'(bus.csrReadEnable), 32'd0);
    check("rst/wren", 32'(bus.csrWriteEnable), 32'd0);
    check("rst/reg", csr300, 32'h12);
    bus.requestValid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rst/reqrdy_after", 32'(bus.requestReady), 32'd1);

    //        name    op      addr     rs1           zimm  hold data          ill lat rd wr wdata
    run_csr("rw1",  3'b001, 12'h300, 32'hDEADBEEF, 5'd0,  0, 32'h12,       0, 3, 1, 1, 32'hDEADBEEF);
    check("rw1/reg", csr300, 32'hDEADBEEF);
    run_csr("rs0",  3'b010, 12'h300, 32'h0,        5'd0,  0, 32'hDEADBEEF, 0, 2, 1, 0, 32'h0);
    run_csr("rw2",  3'b001, 12'h300, 32'h0F,       5'd0,  0, 32'hDEADBEEF, 0, 3, 1, 1, 32'h0F);
    run_csr("rs1",  3'b010, 12'h300, 32'hF0,       5'd0,  0, 32'h0F,       0, 3, 1, 1, 32'hFF);
    run_csr("rc1",  3'b011, 12'h300, 32'h0F,       5'd0,  0, 32'hFF,       0, 3, 1, 1, 32'hF0);
    run_csr("rsi0", 3'b110, 12'h300, 32'hFFFF,     5'd0,  0, 32'hF0,       0, 2, 1, 0, 32'h0);
    run_csr("rci",  3'b111, 12'h300, 32'hFFFF,     5'h10, 0, 32'hF0,       0, 3, 1, 1, 32'hE0);
    run_csr("rwi",  3'b101, 12'h300, 32'hAAAA,     5'd5,  0, 32'hE0,       0, 3, 1, 1, 32'h5);
    run_csr("rwz",  3'b001, 12'h300, 32'h0,        5'd0,  0, 32'h5,        0, 3, 1, 1, 32'h0);
    run_csr("rc0",  3'b011, 12'h300, 32'h0,        5'd0,  0, 32'h0,        0, 2, 1, 0, 32'h0);
    run_csr("unmap",3'b001, 12'h7C0, 32'h1234,     5'd0,  0, 32'h0,        1, 2, 1, 0, 32'h0);
    run_csr("rowr", 3'b001, 12'hC00, 32'h1,        5'd0,  0, 32'h0,        1, 2, 1, 0, 32'h0);
    run_csr("rord", 3'b010, 12'hC00, 32'h0,        5'd0,  0, 32'hABCD,     0, 2, 1, 0, 32'h0);
    run_csr("f100", 3'b100, 12'h300, 32'h1,        5'd0,  0, 32'h0,        1, 1, 0, 0, 32'h0);
    run_csr("f000", 3'b000, 12'h300, 32'h1,        5'd0,  0, 32'h0,        1, 1, 0, 0, 32'h0);
    run_csr("bp",   3'b010, 12'hC00, 32'h0,        5'd0,  5, 32'hABCD,     0, 2, 1, 0, 32'h0);
    check("bp/reg", csr300, 32'h0);

    // Reset asserted while the write strobe is up: nothing may commit.
    begin
      int wr0;
      wr0 = wr_cnt;
      bus.requestValid   = 1'b1;
      bus.requestOp      = 3'b001;
      bus.requestAddress = 12'h300;
      bus.requestRs1Data = 32'h1234;
      @(posedge clk);
      @(negedge clk);
      bus.requestValid = 1'b0;
      check("rstw/rden", 32'(bus.csrReadEnable), 32'd1);
      @(negedge clk);
      check("rstw/wren_pre", 32'(bus.csrWriteEnable), 32'd1);
      check("rstw/wdata_pre", bus.csrWriteData, 32'h1234);
      rst = 1'b0;
      #1;
      check("rstw/wren", 32'(bus.csrWriteEnable), 32'd0);
      check("rstw/wdata", bus.csrWriteData, 32'h0);
      check("rstw/reqrdy", 32'(bus.requestReady), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rstw/writes", wr_cnt - wr0, 0);
      check("rstw/reg", csr300, 32'h0);
      check("rstw/rspvld", 32'(bus.responseValid), 32'd0);
      check("rstw/reqrdy_after", 32'(bus.requestReady), 32'd1);
    end

    run_csr("post", 3'b010, 12'h300, 32'h0,        5'd0,  0, 32'h0,        0, 2, 1, 0, 32'h0);
    check("bus_hygiene", bus_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
